// File: rtl/rsc_pkg.sv
// Shared definitions for the RSC frame encoder: FSM state codes, default
// generator polynomials and the parity-reduction helper.
package rsc_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_TAIL = 2'd2;

  localparam logic [3:0] RSC_G_FB_DEF = 4'b1101;
  localparam logic [3:0] RSC_G_FF_DEF = 4'b1011;

  // Widest polynomial is MEM=6, i.e. 7 taps; callers zero-extend to 8 bits.
  function automatic logic parity_reduce(input logic [7:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/rsc_frame_encoder_if.sv
// Data-in / code-pair-out handshake bundle of the RSC frame encoder.
// out_par_keep exists only when RSC_PUNCTURE_EN is defined.
interface rsc_frame_encoder_if;

  logic start;
  logic in_valid;
  logic in_ready;
  logic in_bit;
  logic out_valid;
  logic out_ready;
  logic out_sys;
  logic out_par;
  logic out_tail;
  logic out_last;
`ifdef RSC_PUNCTURE_EN
  logic out_par_keep;
`endif

  modport slave (
    input  start,
    input  in_valid,
    input  in_bit,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sys,
    output out_par,
    output out_tail,
    output out_last
`ifdef RSC_PUNCTURE_EN
    , output out_par_keep
`endif
  );

  modport master (
    output start,
    output in_valid,
    output in_bit,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sys,
    input  out_par,
    input  out_tail,
    input  out_last
`ifdef RSC_PUNCTURE_EN
    , input out_par_keep
`endif
  );

endinterface

// File: rtl/rsc_core.sv
// Recursive systematic convolutional core: feedback/parity taps and the
// MEM-stage shift register, advanced only on an accepted step.
module rsc_core
  import rsc_pkg::*;
#(
  parameter int             MEM  = 3,
  parameter logic [MEM:0]   G_FB = (MEM+1)'(RSC_G_FB_DEF),
  parameter logic [MEM:0]   G_FF = (MEM+1)'(RSC_G_FF_DEF)
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           step_i,
  input  logic           tail_i,
  input  logic           in_bit_i,
  output logic           sys_o,
  output logic           par_o,
  output logic [MEM-1:0] q_o
);

  logic [MEM-1:0] r_q;
  logic [MEM-1:0] r_d;
  logic [MEM:0]   taps;
  logic           fb;
  logic           u;
  logic           a;

  // taps[k] is r[k]; r[1] is the newest stage, held in the MSB of r_q.
  always_comb begin
    taps = '0;
    for (int k = 1; k <= MEM; k++) begin
      taps[k] = r_q[MEM-k];
    end
    fb    = parity_reduce(8'(G_FB & taps));
    u     = tail_i ? fb : in_bit_i;
    a     = u ^ fb;
    par_o = (G_FF[0] & a) ^ parity_reduce(8'(G_FF & taps));
    sys_o = u;
    r_d   = {a, r_q[MEM-1:1]};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_q <= '0;
    end else if (step_i) begin
      r_q <= r_d;
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/rsc_frame_encoder.sv
// Frame-level RSC encoder: IDLE/DATA/TAIL sequencing, trellis termination and
// a one-deep registered output stage. Optional RSC_PUNCTURE_EN adds out_par_keep.
module rsc_frame_encoder
  import rsc_pkg::*;
#(
  parameter int           MEM       = 3,
  parameter logic [MEM:0] G_FB      = (MEM+1)'(RSC_G_FB_DEF),
  parameter logic [MEM:0] G_FF      = (MEM+1)'(RSC_G_FF_DEF),
  parameter int           FRAME_LEN = 40
) (
  input  logic                  clk,
  input  logic                  clr,
  rsc_frame_encoder_if.slave    bus,
  output logic                  busy,
  output logic [MEM-1:0]        Q
);

  localparam int DCW = $clog2(FRAME_LEN + 1);
  localparam int TCW = $clog2(MEM + 1);

  logic [1:0]     state_q, state_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           out_valid_q, out_valid_d;
  logic           out_sys_q, out_sys_d;
  logic           out_par_q, out_par_d;
  logic           out_tail_q, out_tail_d;
  logic           out_last_q, out_last_d;
`ifdef RSC_PUNCTURE_EN
  logic           keep_q, keep_d;
`endif

  logic can_load;
  logic data_step;
  logic tail_step;
  logic step;
  logic last_tail;
  logic core_sys;
  logic core_par;

  rsc_core #(
    .MEM  (MEM),
    .G_FB (G_FB),
    .G_FF (G_FF)
  ) u_core (
    .clk      (clk),
    .clr      (clr),
    .step_i   (step),
    .tail_i   (state_q == ST_TAIL),
    .in_bit_i (bus.in_bit),
    .sys_o    (core_sys),
    .par_o    (core_par),
    .q_o      (Q)
  );

  // A new pair may be produced whenever the output slot is empty or draining.
  always_comb begin
    can_load  = !out_valid_q || bus.out_ready;
    data_step = (state_q == ST_DATA) && bus.in_valid && can_load;
    tail_step = (state_q == ST_TAIL) && can_load;
    step      = data_step || tail_step;
    last_tail = tail_step && (tcnt_q == TCW'(MEM - 1));
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_DATA;
          dcnt_d  = '0;
        end
      end
      ST_DATA: begin
        if (data_step) begin
          dcnt_d = dcnt_q + DCW'(1);
          if (dcnt_q == DCW'(FRAME_LEN - 1)) begin
            state_d = ST_TAIL;
            tcnt_d  = '0;
          end
        end
      end
      ST_TAIL: begin
        if (tail_step) begin
          tcnt_d = tcnt_q + TCW'(1);
          if (last_tail) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output slot: load on every step, otherwise empty once the pair is taken.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sys_d   = out_sys_q;
    out_par_d   = out_par_q;
    out_tail_d  = out_tail_q;
    out_last_d  = out_last_q;
`ifdef RSC_PUNCTURE_EN
    keep_d      = keep_q;
`endif
    if (step) begin
      out_valid_d = 1'b1;
      out_sys_d   = core_sys;
      out_par_d   = core_par;
      out_tail_d  = tail_step;
      out_last_d  = last_tail;
`ifdef RSC_PUNCTURE_EN
      keep_d      = tail_step | ~dcnt_q[0];
`endif
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      dcnt_q      <= '0;
      tcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_sys_q   <= 1'b0;
      out_par_q   <= 1'b0;
      out_tail_q  <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef RSC_PUNCTURE_EN
      keep_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      tcnt_q      <= tcnt_d;
      out_valid_q <= out_valid_d;
      out_sys_q   <= out_sys_d;
      out_par_q   <= out_par_d;
      out_tail_q  <= out_tail_d;
      out_last_q  <= out_last_d;
`ifdef RSC_PUNCTURE_EN
      keep_q      <= keep_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == ST_DATA) && can_load;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sys   = out_sys_q;
  assign bus.out_par   = out_par_q;
  assign bus.out_tail  = out_tail_q;
  assign bus.out_last  = out_last_q;
`ifdef RSC_PUNCTURE_EN
  assign bus.out_par_keep = keep_q;
`endif
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: doc/rsc_frame_encoder.md
RSC_FRAME_ENCODER -- requirements
Module: rsc_frame_encoder

Interface
REQ-001 SHALL have parameter MEM, default 3: number of constituent shift-register stages, legal range 2..6.
REQ-002 SHALL have parameter G_FB, default 4'b1101: feedback polynomial [MEM:0], bit k is the coefficient of D^k, and bit 0 SHALL be 1.
REQ-003 SHALL have parameter G_FF, default 4'b1011: parity (feed-forward) polynomial [MEM:0], same bit convention.
REQ-004 SHALL have parameter FRAME_LEN, default 40: data bits per frame, legal range 1..6144.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port clr, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: one-cycle pulse that opens a frame.
REQ-008 SHALL have port in_valid/in_ready, input/output, 1 bit each: data-bit handshake.
REQ-009 SHALL have port in_bit, input, 1 bit: systematic data bit.
REQ-010 SHALL have port out_valid/out_ready, output/input, 1 bit each: code-pair handshake.
REQ-011 SHALL have port out_sys, output, 1 bit: systematic or tail bit.
REQ-012 SHALL have port out_par, output, 1 bit: parity bit.
REQ-013 SHALL have port out_tail, output, 1 bit: high when the current pair is a termination pair.
REQ-014 SHALL have port out_last, output, 1 bit: high on the final tail pair.
REQ-015 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-016 SHALL have port Q, output, MEM bits: encoder state r[1..MEM], with Q[MEM-1] = r[1], the newest stage.

Function
REQ-017 SHALL implement the FSM IDLE -> DATA (on start) -> TAIL (after FRAME_LEN data transfers) -> IDLE (after MEM tail transfers); start SHALL be ignored outside IDLE.
REQ-018 SHALL compute the feedback bit a = u XOR (XOR over k=1..MEM of G_FB[k]&r[k]).
REQ-019 SHALL compute parity = (G_FF[0]&a) XOR (XOR over k=1..MEM of G_FF[k]&r[k]).
REQ-020 SHALL update state on each accepted step as r[1] <= a and r[k] <= r[k-1].
REQ-021 SHALL, in DATA, use u = in_bit and assert in_ready = !out_valid || out_ready; a step is accepted on in_valid && in_ready.
REQ-022 SHALL, in TAIL, use u = XOR over k of G_FB[k]&r[k] (so a = 0), require no input, and assert in_ready = 0.
REQ-023 SHALL step one tail bit whenever !out_valid || out_ready.
REQ-024 SHALL register the outputs: the pair for a step accepted in cycle N appears with out_valid=1 in cycle N+1 (latency 1).
REQ-025 SHALL hold out_* stable while out_valid && !out_ready; this gives full throughput of one pair per cycle.
REQ-026 SHALL ensure Q equals 0 after the last tail step.
REQ-027 SHALL assert out_last with the MEM-th tail pair.
REQ-028 SHALL return the FSM to IDLE on the cycle that pair is generated; the final pair drains normally from IDLE.
REQ-029 SHALL let a start that arrives while the final pair is still pending open the next frame, with the first new pair queued behind the pending one (no loss).
REQ-030 SHALL use a data counter of width clog2(FRAME_LEN+1) and a tail counter of width clog2(MEM+1), each cleared on entry to its state.

Reset
REQ-031 SHALL, while clr=1 on a clock edge, put the FSM in IDLE and set Q=0, both counters=0, and out_valid, out_sys, out_par, out_tail, out_last=0.
REQ-032 SHALL, when clr occurs mid-frame, abort the frame with no tail emitted and drop any pending pair.
REQ-033 SHALL give clr priority over start, in_valid and out_ready.

Configuration
REQ-034 SHALL, with RSC_PUNCTURE_EN defined, add output out_par_keep (1 bit): 1 on even-indexed data pairs (index 0, 2, ...), 0 on odd, and 1 on all tail pairs (rate-1/2 puncturing flag), reset value 0.
REQ-035 SHALL, without RSC_PUNCTURE_EN, omit the out_par_keep port; behaviour is otherwise identical.

Structure
REQ-036 SHALL place the FSM state enum, the default G_FB/G_FF constants and a parity-reduction function in the shared package rsc_pkg.
REQ-037 SHALL implement the shift register, feedback and parity logic in sub-module rsc_core (combinational next-state plus enabled state register); the FSM, counters and output register live in rsc_frame_encoder.

Verification
REQ-038 SHALL cover: defaults, FRAME_LEN=1, start, in_bit=1, out_ready=1 -> pairs (sys,par) = (1,1),(0,1),(1,0),(1,1); out_tail=0,1,1,1; out_last only on the 4th; final Q=000.
REQ-039 SHALL cover: defaults, FRAME_LEN=40, random bits, out_ready toggled randomly -> 43 pairs matching the reference model, no duplicates or drops, Q=0 at end.
REQ-040 SHALL cover: out_ready held 0 for 5 cycles mid-DATA -> in_ready=0 and the output stable throughout; resume without loss.
REQ-041 SHALL cover: clr asserted at data bit 10 -> next cycle busy=0, out_valid=0, Q=0; a new start encodes a fresh frame correctly.
REQ-042 SHALL cover: start pulsed during DATA and TAIL -> ignored; start on the out_last handshake cycle -> back-to-back frames with a continuous stream.
REQ-043 SHALL cover: with RSC_PUNCTURE_EN, FRAME_LEN=4 -> out_par_keep = 1,0,1,0,1,1,1.
